// File: rtl/alu_output_stage_pkg.sv
// Shared constants for the SAP datapath: widths, control-word bit positions, opcodes.
package alu_output_stage_pkg;
    localparam int SAP_DATA_W = 8;

    // Control-word bit positions, MSB first
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE
    } sap_op_e;

    typedef struct packed {
        logic c;
        logic z;
    } alu_flags_t;
endpackage

// File: rtl/alu_output_stage_if.sv
// Control, bus and output-port signals between the sequencer/consumer and the ALU output stage.
interface alu_output_stage_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] bus_in;
    logic              Su;
    logic              Eu;
    logic              Lb;
    logic              Lo;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              flag_c;
    logic              flag_z;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_ovf;

    modport slave (
        input  a_in, bus_in, Su, Eu, Lb, Lo, out_ready,
        output bus_out, bus_oe, flag_c, flag_z, out_data, out_valid, out_ovf
    );

    modport master (
        output a_in, bus_in, Su, Eu, Lb, Lo, out_ready,
        input  bus_out, bus_oe, flag_c, flag_z, out_data, out_valid, out_ovf
    );
endinterface

// File: rtl/alu_output_stage_out_fifo.sv
// Synchronous output FIFO with valid/ready read side and sticky overflow on dropped pushes.
module out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push  = i_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push_req & ~w_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/alu_output_stage.sv
// B register, add/subtract ALU with registered flags, gated bus driver and buffered output port.
module alu_output_stage
    import alu_output_stage_pkg::*;
#(
    parameter int DATA_W    = SAP_DATA_W,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_output_stage_if.slave   io
);
    logic [DATA_W-1:0] r_b;
    alu_flags_t        r_flags;
    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_res;

    // Subtract as A + ~B + 1 so the carry out reads as "no borrow"
    assign w_b_op = io.Su ? ~r_b : r_b;
    assign w_res  = {1'b0, io.a_in} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, io.Su};

    assign io.bus_oe  = io.Eu & reset;
    assign io.bus_out = io.bus_oe ? w_res[DATA_W-1:0] : '0;
    assign io.flag_c  = r_flags.c;
    assign io.flag_z  = r_flags.z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b     <= '0;
            r_flags <= '0;
        end else begin
            if (io.Lb) r_b <= io.bus_in;
            if (io.Eu) begin
                r_flags.c <= w_res[DATA_W];
                r_flags.z <= (w_res[DATA_W-1:0] == '0);
            end
        end
    end

    out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_req (io.Lo),
        .i_data     (io.bus_in),
        .i_ready    (io.out_ready),
        .o_data     (io.out_data),
        .o_valid    (io.out_valid),
        .o_ovf      (io.out_ovf)
    );
endmodule

// File: tb/tb_alu_output_stage.sv
// Directed ALU/B-register checks plus a queue scoreboard on the output FIFO port.
module tb_alu_output_stage;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_tot = 0;
    int   n_bad = 0;

    alu_output_stage_if #(.DATA_W(DW)) io ();

    alu_output_stage #(.DATA_W(DW), .OUT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: sampled 1 time unit before each posedge, when inputs and state are settled
    logic [DW-1:0] sb_q [$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_exp;

    always @(negedge clk) begin
        #4;
        if (!reset) begin
            sb_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            chk("out_valid", {31'b0, io.out_valid}, {31'b0, m_cnt != 0});
            chk("out_ovf", {31'b0, io.out_ovf}, {31'b0, m_ovf});
            if (m_cnt != 0 && io.out_ready) begin
                m_exp = sb_q.pop_front();
                chk("out_data", {24'b0, io.out_data}, {24'b0, m_exp});
                m_cnt--;
            end
            if (io.Lo) begin
                if (m_cnt < DEPTH) begin
                    sb_q.push_back(io.bus_in);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        io.Lb = 1'b0; io.Eu = 1'b0; io.Su = 1'b0; io.Lo = 1'b0;
    endtask

    task automatic load_b(input logic [DW-1:0] v);
        cyc();
        io.bus_in = v; io.Lb = 1'b1;
    endtask

    task automatic alu(input logic [DW-1:0] a, input logic su, input logic [DW-1:0] exp, input string tag);
        cyc();
        io.a_in = a; io.Su = su; io.Eu = 1'b1;
        #1;
        chk(tag, {24'b0, io.bus_out}, {24'b0, exp});
        chk("bus_oe", {31'b0, io.bus_oe}, 32'd1);
    endtask

    task automatic flags(input logic c, input logic z, input string tag);
        cyc();
        #1;
        chk({tag, "_c"}, {31'b0, io.flag_c}, {31'b0, c});
        chk({tag, "_z"}, {31'b0, io.flag_z}, {31'b0, z});
        chk("bus_out_idle", {24'b0, io.bus_out}, 32'd0);
    endtask

    task automatic push(input logic [DW-1:0] v, input logic rdy);
        cyc();
        io.bus_in = v; io.Lo = 1'b1; io.out_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        io.a_in = '0; io.bus_in = '0; io.Su = 1'b0; io.Eu = 1'b0;
        io.Lb = 1'b0; io.Lo = 1'b0; io.out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'b0, io.out_valid}, 32'd0);
        chk("rst_data", {24'b0, io.out_data}, 32'd0);
        chk("rst_ovf", {31'b0, io.out_ovf}, 32'd0);
        chk("rst_flag_c", {31'b0, io.flag_c}, 32'd0);
        chk("rst_flag_z", {31'b0, io.flag_z}, 32'd0);
        chk("rst_oe", {31'b0, io.bus_oe}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic add, carry and subtract
        load_b(8'h0A);
        alu(8'h09, 1'b0, 8'h13, "add_09_0a");
        flags(1'b0, 1'b0, "f_add");
        load_b(8'h01);
        alu(8'hFF, 1'b0, 8'h00, "add_wrap");
        flags(1'b1, 1'b1, "f_wrap");
        load_b(8'h07);
        alu(8'h05, 1'b1, 8'hFE, "sub_borrow");
        flags(1'b0, 1'b0, "f_sub");
        load_b(8'h0A);
        alu(8'h0A, 1'b1, 8'h00, "sub_eq");
        flags(1'b1, 1'b1, "f_sub_eq");

        // Lb and Eu together: ALU sees the old B this cycle
        load_b(8'h01);
        cyc();
        io.bus_in = 8'h03; io.Lb = 1'b1; io.a_in = 8'h10; io.Eu = 1'b1;
        #1;
        chk("lb_eu_old", {24'b0, io.bus_out}, 32'h11);
        alu(8'h10, 1'b0, 8'h13, "lb_eu_new");

        // In-order drain with backpressure
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            chk("hold_head", {24'b0, io.out_data}, 32'h11);
        end
        cyc();
        io.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("drained", {31'b0, io.out_valid}, 32'd0);

        // Overflow drop, then full+push+pop accepted
        for (int i = 0; i < DEPTH; i++) push(8'hA1 + 8'(i), 1'b0);
        push(8'h55, 1'b0);
        cyc();
        #1;
        chk("ovf_set", {31'b0, io.out_ovf}, 32'd1);
        chk("ovf_head", {24'b0, io.out_data}, 32'hA1);
        push(8'h66, 1'b1);
        for (int i = 0; i < 6; i++) cyc();
        #1;
        chk("ovf_sticky", {31'b0, io.out_ovf}, 32'd1);
        chk("drained2", {31'b0, io.out_valid}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        // Mid-run reset with 3 queued entries and a live carry flag
        load_b(8'h03);
        alu(8'hFF, 1'b0, 8'h02, "pre_rst");
        io.out_ready = 1'b0;
        push(8'h71, 1'b0);
        push(8'h72, 1'b0);
        push(8'h73, 1'b0);
        cyc();
        io.Eu = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, io.out_valid}, 32'd0);
        chk("mid_rst_oe", {31'b0, io.bus_oe}, 32'd0);
        chk("mid_rst_ovf", {31'b0, io.out_ovf}, 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("post_rst_c", {31'b0, io.flag_c}, 32'd0);
        chk("post_rst_z", {31'b0, io.flag_z}, 32'd0);
        alu(8'h05, 1'b0, 8'h05, "post_rst_b0");
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
